memory_stage: RTL and testbench

//  Pipeline stage directly downstream of execute_stage. Consumes execute's registered outputs,

---
 rtl/memory_stage_if.sv | 63 ++++++
 rtl/memory_stage.sv | 149 ++++++++++++++
 tb/tb_memory_stage.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - execute/data-bus/writeback signal bundle for memory_stage
// Purpose: groups every memory_stage port except clk/resetn.
//   slave  : the stage itself (consumes execute + data bus + ready_i, drives done/fwd/writeback)
//   master : the environment (execute stage, data bus, writeback stage)
// Ports (all in the bundle):
//   data_data_ok, data_rdata                 data bus response
//   valid_i, pc_i, inst_i, ctrl_i, result_i  execute outputs
//   eaddr_i, rdata2_i, waddr_i               execute outputs
//   ready_i                                  writeback accepts
//   done_o, fwd_addr, fwd_data, fwd_ok       stage status / forwarding
//   valid_o, pc_o, inst_o, ctrl_o, result_o, waddr_o  registered toward writeback
// Control bit positions come from the shared `I_* definitions below.

`ifndef I_MAX
`define I_MAX   9
`define I_MEM_R 0
`define I_MEM_W 1
`define I_LB    2
`define I_LBU   3
`define I_LH    4
`define I_LHU   5
`define I_LW    6
`define I_LWL   7
`define I_LWR   8
`endif

interface memory_stage_if;
  logic              data_data_ok;
  logic [31:0]       data_rdata;
  logic              valid_i;
  logic [31:0]       pc_i;
  logic [31:0]       inst_i;
  logic [`I_MAX-1:0] ctrl_i;
  logic [31:0]       result_i;
  logic [31:0]       eaddr_i;
  logic [31:0]       rdata2_i;
  logic [4:0]        waddr_i;
  logic              ready_i;
  logic              done_o;
  logic [4:0]        fwd_addr;
  logic [31:0]       fwd_data;
  logic              fwd_ok;
  logic              valid_o;
  logic [31:0]       pc_o;
  logic [31:0]       inst_o;
  logic [`I_MAX-1:0] ctrl_o;
  logic [31:0]       result_o;
  logic [4:0]        waddr_o;

  modport slave (
    input  data_data_ok, data_rdata, valid_i, pc_i, inst_i, ctrl_i, result_i,
           eaddr_i, rdata2_i, waddr_i, ready_i,
    output done_o, fwd_addr, fwd_data, fwd_ok,
           valid_o, pc_o, inst_o, ctrl_o, result_o, waddr_o
  );

  modport master (
    output data_data_ok, data_rdata, valid_i, pc_i, inst_i, ctrl_i, result_i,
           eaddr_i, rdata2_i, waddr_i, ready_i,
    input  done_o, fwd_addr, fwd_data, fwd_ok,
           valid_o, pc_o, inst_o, ctrl_o, result_o, waddr_o
  );
endinterface

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - memory pipeline stage: waits for data response, aligns loads, registers to writeback
// Purpose: sits after execute. For memory ops it waits for data_data_ok (one outstanding
//   request), captures the read data if writeback stalls, extracts LB/LBU/LH/LHU/LW/LWL/LWR,
//   and registers the result toward writeback. Exposes done_o and forwarding.
// Ports:
//   clk     in  clock, posedge
//   resetn  in  synchronous reset, active low
//   bus     memory_stage_if.slave (execute inputs, data bus, ready_i, done/fwd, writeback outputs)
// Configuration macro: MEM_LOAD_FWD_EN - when defined, loads forward in their data_data_ok/HOLD
//   cycle; otherwise loads forward only from writeback.

`ifndef I_MAX
`define I_MAX   9
`define I_MEM_R 0
`define I_MEM_W 1
`define I_LB    2
`define I_LBU   3
`define I_LH    4
`define I_LHU   5
`define I_LW    6
`define I_LWL   7
`define I_LWR   8
`endif

module memory_stage (
  input  logic           clk,
  input  logic           resetn,
  memory_stage_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

  state_t      state;
  logic        done;
  logic [31:0] hold_data;

  logic        mem_op;
  logic        valid;
  logic        done_now;
  logic [31:0] r;
  logic [31:0] rt;
  logic [1:0]  o;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] final_data;
  logic        unused_eaddr;

  assign mem_op   = bus.ctrl_i[`I_MEM_R] | bus.ctrl_i[`I_MEM_W];
  // done blocks a second launch of the same instruction while writeback stalls
  assign valid    = bus.valid_i & ~done;
  assign done_now = ~mem_op | bus.data_data_ok | (state == S_HOLD);
  assign r        = (state == S_HOLD) ? hold_data : bus.data_rdata;
  assign rt       = bus.rdata2_i;
  assign o        = bus.eaddr_i[1:0];
  assign h        = o[1] ? r[31:16] : r[15:0];
  assign unused_eaddr = ^bus.eaddr_i[31:2];

  always_comb begin
    b = r[7:0];
    case (o)
      2'd0: b = r[7:0];
      2'd1: b = r[15:8];
      2'd2: b = r[23:16];
      2'd3: b = r[31:24];
      default: b = r[7:0];
    endcase
  end

  always_comb begin
    final_data = bus.result_i;
    if (bus.ctrl_i[`I_LB])       final_data = {{24{b[7]}}, b};
    else if (bus.ctrl_i[`I_LBU]) final_data = {24'd0, b};
    else if (bus.ctrl_i[`I_LH])  final_data = {{16{h[15]}}, h};
    else if (bus.ctrl_i[`I_LHU]) final_data = {16'd0, h};
    else if (bus.ctrl_i[`I_LW])  final_data = r;
    else if (bus.ctrl_i[`I_LWL]) begin
      case (o)
        2'd0: final_data = {r[7:0],  rt[23:0]};
        2'd1: final_data = {r[15:0], rt[15:0]};
        2'd2: final_data = {r[23:0], rt[7:0]};
        default: final_data = r;
      endcase
    end else if (bus.ctrl_i[`I_LWR]) begin
      case (o)
        2'd0: final_data = r;
        2'd1: final_data = {rt[31:24], r[31:8]};
        2'd2: final_data = {rt[31:16], r[31:16]};
        default: final_data = {rt[31:8], r[31:24]};
      endcase
    end
  end

  assign bus.done_o   = done_now;
  assign bus.fwd_addr = {5{bus.valid_i}} & bus.waddr_i;
  assign bus.fwd_data = final_data;
`ifdef MEM_LOAD_FWD_EN
  assign bus.fwd_ok   = bus.valid_i & done_now;
`else
  // keeps data_rdata out of the forwarding-mux timing path
  assign bus.fwd_ok   = bus.valid_i & done_now & ~bus.ctrl_i[`I_MEM_R];
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      done         <= 1'b0;
      hold_data    <= 32'd0;
      bus.valid_o  <= 1'b0;
      bus.pc_o     <= 32'd0;
      bus.inst_o   <= 32'd0;
      bus.ctrl_o   <= '0;
      bus.result_o <= 32'd0;
      bus.waddr_o  <= 5'd0;
    end else begin
      case (state)
        // data_data_ok with no request in flight is ignored here
        S_IDLE: if (valid & mem_op) begin
          if (!bus.data_data_ok) begin
            state <= S_WAIT;
          end else if (!bus.ready_i) begin
            state     <= S_HOLD;
            hold_data <= bus.data_rdata;
          end
        end
        S_WAIT: if (bus.data_data_ok) begin
          if (bus.ready_i) begin
            state <= S_IDLE;
          end else begin
            state     <= S_HOLD;
            hold_data <= bus.data_rdata;
          end
        end
        S_HOLD: if (bus.ready_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (bus.ready_i)                       done <= 1'b0;
      else if (bus.valid_i & done_now)       done <= 1'b1;

      if (bus.ready_i) begin
        bus.valid_o  <= bus.valid_i & done_now;
        bus.pc_o     <= bus.pc_i;
        bus.inst_o   <= bus.inst_i;
        bus.ctrl_o   <= bus.ctrl_i;
        bus.result_o <= final_data;
        bus.waddr_o  <= bus.waddr_i;
      end
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage with a transaction-level model

`ifndef I_MAX
`define I_MAX   9
`define I_MEM_R 0
`define I_MEM_W 1
`define I_LB    2
`define I_LBU   3
`define I_LH    4
`define I_LHU   5
`define I_LW    6
`define I_LWL   7
`define I_LWR   8
`endif

module tb_memory_stage;
  localparam int K_ADDU = 0, K_SW = 1, K_LB = 2, K_LBU = 3, K_LH = 4,
                 K_LHU = 5, K_LW = 6, K_LWL = 7, K_LWR = 8;
`ifdef MEM_LOAD_FWD_EN
  localparam bit LOAD_FWD = 1'b1;
`else
  localparam bit LOAD_FWD = 1'b0;
`endif

  typedef struct {
    bit          v;
    int          kind;
    logic [31:0] pc, inst, result, eaddr, rdata2, rdata;
    logic [4:0]  waddr;
    int          delay;
    bit          has_lit;
    logic [31:0] lit;
  } instr_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  memory_stage_if bus();
  memory_stage dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  instr_t cur;
  instr_t dq[$];
  bit     rq[$];
  int     age;
  bit     resp_seen;
  logic   exp_valid_o;
  logic [31:0] exp_pc, exp_inst, exp_res;
  logic [4:0]  exp_waddr;
  logic [`I_MAX-1:0] exp_ctrl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mem(input int k);
    return k != K_ADDU;
  endfunction

  function automatic bit is_load(input int k);
    return k >= K_LB;
  endfunction

  function automatic logic [`I_MAX-1:0] ctrl_of(input int k);
    logic [`I_MAX-1:0] c;
    c = '0;
    case (k)
      K_SW:  c[`I_MEM_W] = 1'b1;
      K_LB:  begin c[`I_MEM_R] = 1'b1; c[`I_LB]  = 1'b1; end
      K_LBU: begin c[`I_MEM_R] = 1'b1; c[`I_LBU] = 1'b1; end
      K_LH:  begin c[`I_MEM_R] = 1'b1; c[`I_LH]  = 1'b1; end
      K_LHU: begin c[`I_MEM_R] = 1'b1; c[`I_LHU] = 1'b1; end
      K_LW:  begin c[`I_MEM_R] = 1'b1; c[`I_LW]  = 1'b1; end
      K_LWL: begin c[`I_MEM_R] = 1'b1; c[`I_LWL] = 1'b1; end
      K_LWR: begin c[`I_MEM_R] = 1'b1; c[`I_LWR] = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Load result from byte-lane arithmetic: shifts, masks and two's-complement wrap.
  function automatic logic [31:0] extract(input int k, input logic [31:0] r, input logic [31:0] rt,
                                          input logic [31:0] res, input int o);
    logic [31:0] byt, half;
    logic [63:0] t, m;
    byt  = (r >> (8 * o)) & 32'h0000_00FF;
    half = (r >> (16 * (o / 2))) & 32'h0000_FFFF;
    case (k)
      K_LB:  return (byt  >= 32'd128)   ? byt  - 32'd256   : byt;
      K_LBU: return byt;
      K_LH:  return (half >= 32'd32768) ? half - 32'd65536 : half;
      K_LHU: return half;
      K_LW:  return r;
      K_LWL: begin
        t = {32'd0, r} << (8 * (3 - o));
        m = (64'd1 << (8 * (3 - o))) - 64'd1;
        return t[31:0] | (rt & m[31:0]);
      end
      K_LWR: return (r >> (8 * o)) | (rt & ~(32'hFFFF_FFFF >> (8 * o)));
      default: return res;
    endcase
  endfunction

  function automatic logic [31:0] final_of(input instr_t i);
    return extract(i.kind, i.rdata, i.rdata2, i.result, int'(i.eaddr[1:0]));
  endfunction

  function automatic instr_t mk(input int k, input logic [31:0] eaddr, input logic [31:0] rt,
                                input logic [31:0] rd, input logic [31:0] res, input logic [4:0] wa,
                                input int dly, input logic [31:0] lit);
    instr_t i;
    i.v = 1'b1; i.kind = k; i.pc = $urandom; i.inst = $urandom; i.result = res;
    i.eaddr = eaddr; i.rdata2 = rt; i.rdata = rd; i.waddr = wa; i.delay = dly;
    i.has_lit = 1'b1; i.lit = lit;
    return i;
  endfunction

  task automatic next_instr();
    instr_t i;
    if (dq.size() > 0) begin
      i = dq.pop_front();
    end else begin
      i.v = ($urandom_range(0, 4) != 0);
      i.kind = i.v ? int'($urandom_range(0, 8)) : K_ADDU;
      i.pc = $urandom; i.inst = $urandom; i.result = $urandom; i.eaddr = $urandom;
      i.rdata2 = $urandom; i.rdata = $urandom;
      i.waddr = (i.kind == K_SW) ? 5'd0 : 5'($urandom_range(0, 31));
      i.delay = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 4));
      i.has_lit = 1'b0; i.lit = 32'd0;
    end
    cur = i;
    age = 0;
    resp_seen = 1'b0;
  endtask

  // One clock of stimulus plus comparison. Entered just after a posedge.
  task automatic cycle();
    bit rdy, mem, dn;
    logic [31:0] fin;
    mem = cur.v && is_mem(cur.kind);
    if (mem && !resp_seen && age == cur.delay) begin
      bus.data_data_ok = 1'b1;
      bus.data_rdata   = cur.rdata;
      resp_seen        = 1'b1;
    end else begin
      bus.data_data_ok = 1'b0;
      bus.data_rdata   = $urandom;
    end
    rdy = (rq.size() > 0) ? rq.pop_front() : ($urandom_range(0, 2) != 0);
    bus.ready_i  = rdy;
    bus.valid_i  = cur.v;
    bus.pc_i     = cur.pc;
    bus.inst_i   = cur.inst;
    bus.ctrl_i   = cur.v ? ctrl_of(cur.kind) : '0;
    bus.result_i = cur.result;
    bus.eaddr_i  = cur.eaddr;
    bus.rdata2_i = cur.rdata2;
    bus.waddr_i  = cur.waddr;
    dn  = !mem || resp_seen;
    fin = final_of(cur);

    @(negedge clk);
    check("done_o", 32'(bus.done_o), 32'(dn));
    check("fwd_addr", 32'(bus.fwd_addr), cur.v ? 32'(cur.waddr) : 32'd0);
    check("fwd_ok", 32'(bus.fwd_ok), 32'(cur.v && dn && (LOAD_FWD || !is_load(cur.kind))));
    if (cur.v && dn) check("fwd_data", bus.fwd_data, fin);

    @(posedge clk); #1;
    if (rdy) begin
      exp_valid_o = cur.v && dn;
      exp_pc = cur.pc; exp_inst = cur.inst; exp_ctrl = cur.v ? ctrl_of(cur.kind) : '0;
      exp_waddr = cur.waddr; exp_res = fin;
    end
    check("valid_o", 32'(bus.valid_o), 32'(exp_valid_o));
    check("pc_o", bus.pc_o, exp_pc);
    check("inst_o", bus.inst_o, exp_inst);
    check("ctrl_o", 32'(bus.ctrl_o), 32'(exp_ctrl));
    check("waddr_o", 32'(bus.waddr_o), 32'(exp_waddr));
    if (exp_valid_o) check("result_o", bus.result_o, exp_res);
    if (rdy && cur.v && dn && cur.has_lit) begin
      check("lit_result_o", bus.result_o, cur.lit);
      check("lit_model", fin, cur.lit);
    end

    if (!cur.v || (rdy && dn)) next_instr();
    else age++;
  endtask

  task automatic drive_idle();
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0; bus.valid_i = 1'b0;
    bus.pc_i = 32'd0; bus.inst_i = 32'd0; bus.ctrl_i = '0; bus.result_i = 32'd0;
    bus.eaddr_i = 32'd0; bus.rdata2_i = 32'd0; bus.waddr_i = 5'd0; bus.ready_i = 1'b0;
  endtask

  initial begin
    instr_t bub;
    drive_idle();
    exp_valid_o = 1'b0; exp_pc = 32'd0; exp_inst = 32'd0; exp_res = 32'd0;
    exp_waddr = 5'd0; exp_ctrl = '0;

    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", 32'(bus.valid_o), 32'd0);
    check("rst_result_o", bus.result_o, 32'd0);
    check("rst_pc_o", bus.pc_o, 32'd0);
    check("rst_waddr_o", 32'(bus.waddr_o), 32'd0);
    resetn = 1'b1;

    // Model pins on hand-computed values.
    check("pin_lb", extract(K_LB, 32'h0080_0000, 32'd0, 32'd0, 2), 32'hFFFF_FF80);
    check("pin_lbu", extract(K_LBU, 32'h0080_0000, 32'd0, 32'd0, 2), 32'h0000_0080);
    check("pin_lwl", extract(K_LWL, 32'h1122_3344, 32'hAABB_CCDD, 32'd0, 1), 32'h3344_CCDD);
    check("pin_lwr", extract(K_LWR, 32'h1122_3344, 32'hAABB_CCDD, 32'd0, 2), 32'hAABB_1122);

    dq.push_back(mk(K_ADDU, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 5'd3, 0, 32'h1234_5678));
    dq.push_back(mk(K_LB,  32'h1000_0002, 32'h0, 32'h0080_0000, 32'h0, 5'd4, 0, 32'hFFFF_FF80));
    dq.push_back(mk(K_LBU, 32'h1000_0002, 32'h0, 32'h0080_0000, 32'h0, 5'd4, 0, 32'h0000_0080));
    dq.push_back(mk(K_LWL, 32'h2000_0001, 32'hAABB_CCDD, 32'h1122_3344, 32'h0, 5'd6, 0, 32'h3344_CCDD));
    dq.push_back(mk(K_LWR, 32'h2000_0002, 32'hAABB_CCDD, 32'h1122_3344, 32'h0, 5'd6, 0, 32'hAABB_1122));
    dq.push_back(mk(K_LW,  32'h3000_0000, 32'h0, 32'h5555_AAAA, 32'h0, 5'd5, 0, 32'h5555_AAAA));
    dq.push_back(mk(K_LW,  32'h4000_0000, 32'h0, 32'hCAFE_F00D, 32'h0, 5'd7, 3, 32'hCAFE_F00D));
    bub = mk(K_ADDU, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    bub.v = 1'b0; bub.has_lit = 1'b0;
    dq.push_back(bub);
    repeat (6) rq.push_back(1'b1);
    repeat (5) rq.push_back(1'b0);
    rq.push_back(1'b1);
    rq.push_back(1'b1);

    next_instr();
    for (int n = 0; n < 1500; n++) cycle();

    // Reset while a load waits; a stray response afterwards must not be captured.
    drive_idle();
    bus.valid_i = 1'b1; bus.ctrl_i = ctrl_of(K_LW); bus.waddr_i = 5'd9; bus.ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("rstw_valid_o", 32'(bus.valid_o), 32'd0);
    drive_idle();
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_BEEF; bus.ready_i = 1'b0;
    @(posedge clk); #1;
    check("rstw_valid_o_late", 32'(bus.valid_o), 32'd0);
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    bus.valid_i = 1'b1; bus.ctrl_i = ctrl_of(K_LW); bus.waddr_i = 5'd9; bus.ready_i = 1'b1;
    @(negedge clk);
    check("rstw_no_capture", 32'(bus.done_o), 32'd0);
    @(posedge clk); #1;
    check("rstw_valid_o_wait", 32'(bus.valid_o), 32'd0);
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1357_2468;
    @(posedge clk); #1;
    check("rstw_valid_o_done", 32'(bus.valid_o), 32'd1);
    check("rstw_result_o", bus.result_o, 32'h1357_2468);
    drive_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
